exec_mem_unit: RTL and testbench
================================

Name: exec_mem_unit

Overview:
Single-cycle MIPS datapath slice: instruction decode (control unit), 32-bit ALU and word-addressed data memory in one block. Sits between the GRF/NPC and the writeback mux of the single-cycle core. Consumes the fetched instruction, both register operands and PC+4. Produces register-write controls and data, the memory write, and next-PC selection.

Parameters:
DM_WORDS, 3072, number of 32-bit data memory words.
DM_AW, 12, word-index width taken from addr[DM_AW+1:2].

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  reset, asynchronous, active-low (0 = reset)
instr  in  32  current instruction
pc  in  32  address of current instruction (used by display only)
pc4  in  32  pc+4
rs_data  in  32  GRF read port 1 (rs)
rt_data  in  32  GRF read port 2 (rt)
reg_we  out  1  register write enable
reg_waddr  out  5  destination register
reg_wdata  out  32  writeback data
mem_we  out  1  data memory write enable (decoded)
alu_result  out  32  ALU output / memory address
npc_op  out  3  0=pc+4, 1=beq, 2=j/jal, 3=jr
branch_taken  out  1  beq with equal operands

Behaviour:
- Decode on op=instr[31:26] and func=instr[5:0]. All decode and ALU paths are combinational.
- addu (op 0, func 0x21): rs+rt; write rd.
- subu (op 0, func 0x23): rs-rt; write rd.
- jr (op 0, func 0x08): npc_op=3; no writes.
- ori (0x0D): rs | zero-ext imm16; write rt.
- lui (0x0F): imm16<<16; write rt.
- lw (0x23): address rs+sext(imm16); write rt with the memory word.
- sw (0x2B): address rs+sext(imm16); mem_we=1, data=rt_data.
- beq (0x04): npc_op=1; branch_taken=(rs_data==rt_data).
- jal (0x03): npc_op=2; write $31 with pc4.
- Any other encoding (including nop 0x00000000, which decodes as sll): all enables 0, npc_op=0, branch_taken=0.
- Internal ALUOp is 4 bits: add, sub, or, lui, eq.
- Arithmetic wraps mod 2^32. No overflow trap.
- branch_taken is forced 0 for non-beq instructions.
- reg_we asserts even when reg_waddr=0; the GRF discards $0 writes.
- Writeback mux: ALU result for R-type/ori/lui, memory read data for lw, pc4 for jal.
- DM read is combinational: word = mem[alu_result[DM_AW+1:2]]. alu_result[1:0] is ignored.
- DM write occurs on the rising clk edge when mem_we=1 and rst=1.
- Any index >= DM_WORDS: the write is dropped and the read returns 0.
- rst=0 asynchronously clears all DM words to 0 and blocks writes. This includes reset asserted mid-cycle during an sw.
- During reset, combinational outputs still follow instr. DM read data is 0.
- Read-during-write to the same word returns the old value; the new value is visible the next cycle.

Optional Feature:
Macro TRACE_DISPLAY_EN.
- Defined: on each rising clk edge with rst=1, print "@%h: $%d <= %h" (pc, reg_waddr, reg_wdata) when reg_we=1.
- Defined: on the same edge, print "@%h: *%h <= %h" (pc, alu_result, rt_data) when mem_we=1.
- Not defined: no output and no simulation-only code. Logic is identical either way.

Test Plan:
- Drive rst=0, then release it; apply lw 0x8C030004 with rs_data=0 -> reg_we=1, reg_waddr=3, reg_wdata=0x00000000.
- ori 0x34011234, rs_data=0 -> reg_waddr=1, reg_wdata=0x00001234, mem_we=0, npc_op=0.
- sw 0xAC020004, rs_data=0, rt_data=0xDEADBEEF, then one clk -> lw 0x8C030004 gives reg_wdata=0xDEADBEEF. A write to address 0x0000C000 (out of range) -> a later read returns 0.
- beq 0x10220003 with rs=rt=5 -> npc_op=1, branch_taken=1. With rt=6 -> branch_taken=0, reg_we=0.
- jal 0x0C000C00 with pc4=0x00003004 -> reg_waddr=31, reg_wdata=0x00003004, npc_op=2. jr 0x03E00008 -> npc_op=3, reg_we=0.
- addu 0x00221821 with 0xFFFFFFFF+0x1 -> reg_wdata=0. lui 0x3C03ABCD -> 0xABCD0000. Drop rst low mid-run after sw -> stored word reads 0.

Source files
------------

// File: rtl/exec_mem_unit.sv
// rtl/exec_mem_unit.sv - single-cycle MIPS decode, ALU and word-addressed data memory slice
// Optional feature macro: TRACE_DISPLAY_EN (register/memory write trace printing).
module exec_mem_unit #(
    parameter int DM_WORDS = 3072,
    parameter int DM_AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] pc4,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        mem_we,
    output logic [31:0] alu_result,
    output logic [2:0]  npc_op,
    output logic        branch_taken
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_JR = 6'h08;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2, ALU_LUI = 4'd3, ALU_EQ = 4'd4;
    localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2;

    logic [5:0]  w_op, w_func;
    logic [4:0]  w_rt, w_rd;
    logic [3:0]  w_alu_op;
    logic        w_src_imm, w_imm_sext, w_is_beq;
    logic [1:0]  w_wb_sel;
    logic [31:0] w_src_b, w_rdata;
    logic [DM_AW-1:0] w_idx;
    logic        w_in_range;
    logic        w_unused_ok;
    logic [31:0] r_mem [DM_WORDS];

    assign w_op   = instr[31:26];
    assign w_func = instr[5:0];
    assign w_rt   = instr[20:16];
    assign w_rd   = instr[15:11];
    assign w_unused_ok = ^{pc, instr[25:21], instr[10:6]};

    always_comb begin
        w_alu_op   = ALU_ADD;
        w_src_imm  = 1'b0;
        w_imm_sext = 1'b0;
        w_is_beq   = 1'b0;
        w_wb_sel   = WB_ALU;
        reg_we     = 1'b0;
        reg_waddr  = 5'd0;
        mem_we     = 1'b0;
        npc_op     = 3'd0;
        case (w_op)
            OP_RTYPE: begin
                case (w_func)
                    F_ADDU: begin reg_we = 1'b1; reg_waddr = w_rd; end
                    F_SUBU: begin reg_we = 1'b1; reg_waddr = w_rd; w_alu_op = ALU_SUB; end
                    F_JR:   npc_op = 3'd3;
                    default: ;
                endcase
            end
            OP_ORI: begin reg_we = 1'b1; reg_waddr = w_rt; w_alu_op = ALU_OR; w_src_imm = 1'b1; end
            OP_LUI: begin reg_we = 1'b1; reg_waddr = w_rt; w_alu_op = ALU_LUI; w_src_imm = 1'b1; end
            OP_LW: begin
                reg_we = 1'b1; reg_waddr = w_rt; w_src_imm = 1'b1; w_imm_sext = 1'b1; w_wb_sel = WB_MEM;
            end
            OP_SW:  begin mem_we = 1'b1; w_src_imm = 1'b1; w_imm_sext = 1'b1; end
            OP_BEQ: begin npc_op = 3'd1; w_alu_op = ALU_EQ; w_is_beq = 1'b1; end
            OP_JAL: begin reg_we = 1'b1; reg_waddr = 5'd31; npc_op = 3'd2; w_wb_sel = WB_PC4; end
            default: ;
        endcase
    end

    assign w_src_b = !w_src_imm ? rt_data :
                     w_imm_sext ? {{16{instr[15]}}, instr[15:0]} : {16'h0000, instr[15:0]};

    always_comb begin
        case (w_alu_op)
            ALU_ADD: alu_result = rs_data + w_src_b;
            ALU_SUB: alu_result = rs_data - w_src_b;
            ALU_OR:  alu_result = rs_data | w_src_b;
            ALU_LUI: alu_result = {w_src_b[15:0], 16'h0000};
            ALU_EQ:  alu_result = {31'd0, rs_data == rt_data};
            default: alu_result = 32'd0;
        endcase
    end

    assign branch_taken = w_is_beq & alu_result[0];

    // Upper address bits take part in the range check so far addresses never alias onto low words.
    assign w_idx      = alu_result[DM_AW+1:2];
    assign w_in_range = (alu_result[31:DM_AW+2] == '0) && ({1'b0, w_idx} < (DM_AW+1)'(DM_WORDS));
    assign w_rdata    = (rst && w_in_range) ? r_mem[w_idx] : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= 32'd0;
        end else if (mem_we && w_in_range) begin
            r_mem[w_idx] <= rt_data;
        end
    end

    always_comb begin
        case (w_wb_sel)
            WB_MEM:  reg_wdata = w_rdata;
            WB_PC4:  reg_wdata = pc4;
            default: reg_wdata = alu_result;
        endcase
    end

`ifdef TRACE_DISPLAY_EN
    always @(posedge clk) begin
        if (rst) begin
            if (reg_we) $display("@%h: $%d <= %h", pc, reg_waddr, reg_wdata);
            if (mem_we) $display("@%h: *%h <= %h", pc, alu_result, rt_data);
        end
    end
`else
`endif
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb/tb_exec_mem_unit.sv - scoreboard bench for exec_mem_unit with randomized instruction stream
module tb_exec_mem_unit;
    localparam int DM_WORDS = 3072;

    logic        clk, rst;
    logic [31:0] instr, pc, pc4, rs_data, rt_data;
    logic        reg_we, mem_we, branch_taken;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, alu_result;
    logic [2:0]  npc_op;

    exec_mem_unit #(.DM_WORDS(DM_WORDS), .DM_AW(12)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .pc4(pc4),
        .rs_data(rs_data), .rt_data(rt_data),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mem_we(mem_we), .alu_result(alu_result), .npc_op(npc_op),
        .branch_taken(branch_taken)
    );

    typedef struct {
        logic        reg_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mem_we;
        logic [31:0] alu;
        logic        chk_alu;
        logic [31:0] mdata;
        logic [2:0]  npc;
        logic        bt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_model [int unsigned];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (instr %h)", name, act, exp, instr);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input bit in_reset);
        int unsigned w;
        w = addr >> 2;
        if (in_reset || w >= DM_WORDS) return 32'd0;
        return mem_model.exists(w) ? mem_model[w] : 32'd0;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, rs, rt, p4, input bit in_reset);
        exp_t e;
        logic [31:0] sx, zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'h0000, ins[15:0]};
        e = '{reg_we: 1'b0, waddr: 5'd0, wdata: 32'd0, mem_we: 1'b0, alu: 32'd0,
              chk_alu: 1'b0, mdata: rt, npc: 3'd0, bt: 1'b0};
        case (ins[31:26])
            6'h00: begin
                if (ins[5:0] == 6'h21) begin
                    e.reg_we = 1; e.waddr = ins[15:11]; e.alu = rs + rt; e.wdata = rs + rt; e.chk_alu = 1;
                end else if (ins[5:0] == 6'h23) begin
                    e.reg_we = 1; e.waddr = ins[15:11]; e.alu = rs - rt; e.wdata = rs - rt; e.chk_alu = 1;
                end else if (ins[5:0] == 6'h08) e.npc = 3'd3;
            end
            6'h0D: begin e.reg_we = 1; e.waddr = ins[20:16]; e.alu = rs | zx; e.wdata = rs | zx; e.chk_alu = 1; end
            6'h0F: begin e.reg_we = 1; e.waddr = ins[20:16]; e.alu = zx << 16; e.wdata = zx << 16; e.chk_alu = 1; end
            6'h23: begin
                e.reg_we = 1; e.waddr = ins[20:16]; e.alu = rs + sx; e.chk_alu = 1;
                e.wdata = model_read(rs + sx, in_reset);
            end
            6'h2B: begin e.mem_we = 1; e.alu = rs + sx; e.chk_alu = 1; end
            6'h04: begin e.npc = 3'd1; e.bt = (rs == rt); end
            6'h03: begin e.reg_we = 1; e.waddr = 5'd31; e.wdata = p4; e.npc = 3'd2; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [31:0] ins, rs, rt, p4);
        instr = ins; rs_data = rs; rt_data = rt; pc4 = p4; pc = p4 - 32'd4;
    endtask

    // Called at a rising edge; occupies exactly one clock cycle.
    task automatic apply(input logic [31:0] ins, rs, rt, p4);
        exp_t e;
        #1;
        drive(ins, rs, rt, p4);
        e = model(ins, rs, rt, p4, !rst);
        sb_q.push_back(e);
        @(posedge clk);
        if (rst && e.mem_we && (e.alu >> 2) < DM_WORDS) mem_model[e.alu >> 2] = e.mdata;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b0;
        mem_model.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("reg_we", 32'(reg_we), 32'(e.reg_we));
            if (e.reg_we) begin
                chk("reg_waddr", 32'(reg_waddr), 32'(e.waddr));
                chk("reg_wdata", reg_wdata, e.wdata);
            end
            chk("mem_we", 32'(mem_we), 32'(e.mem_we));
            chk("npc_op", 32'(npc_op), 32'(e.npc));
            chk("branch_taken", 32'(branch_taken), 32'(e.bt));
            if (e.chk_alu) chk("alu_result", alu_result, e.alu);
        end
    end

    function automatic logic [31:0] rand_instr(output logic [31:0] rs, output logic [31:0] rt);
        logic [31:0] ins, addr, sx;
        logic [15:0] imm;
        logic [4:0]  f_rs, f_rt, f_rd;
        f_rs = 5'($urandom); f_rt = 5'($urandom); f_rd = 5'($urandom);
        rs = $urandom; rt = $urandom;
        imm = 16'($urandom);
        case ($urandom_range(0, 11))
            0: ins = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h21};
            1: ins = {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h23};
            2: ins = {6'h00, f_rs, 15'd0, 6'h08};
            3: ins = {6'h0D, f_rs, f_rt, imm};
            4: ins = {6'h0F, 5'd0, f_rt, imm};
            5, 6, 7: begin
                imm = 16'($urandom_range(0, 255)) - 16'd128;
                sx  = {{16{imm[15]}}, imm};
                case ($urandom_range(0, 5))
                    0: addr = 32'((DM_WORDS + $urandom_range(0, 3)) * 4) + 32'($urandom_range(0, 3));
                    1: addr = 32'h0000_C000;
                    2: addr = 32'((DM_WORDS - 1) * 4);
                    default: addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
                endcase
                rs  = addr - sx;
                ins = {($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B, f_rs, f_rt, imm};
            end
            8: begin
                if ($urandom_range(0, 1) != 0) rt = rs;
                ins = {6'h04, f_rs, f_rt, imm};
            end
            9:  ins = {6'h03, 26'($urandom)};
            10: ins = 32'h0000_0000;
            default: ins = ($urandom_range(0, 1) != 0) ? {6'h08, 26'($urandom)}
                                                       : {6'h00, f_rs, f_rt, f_rd, 5'd0, 6'h20};
        endcase
        return ins;
    endfunction

    initial begin
        logic [31:0] ins, rs, rt;
        exp_t e;
        rst = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 32'd4);
        @(posedge clk);
        apply(32'h8C030004, 32'd0, 32'd0, 32'd4);
        rst = 1'b1;
        @(posedge clk);

        apply(32'h8C030004, 32'd0, 32'd0, 32'h0000_1004);
        apply(32'h34011234, 32'd0, 32'd0, 32'h0000_1008);
        apply(32'hAC020004, 32'd0, 32'hDEADBEEF, 32'h0000_100C);
        apply(32'h8C030004, 32'd0, 32'd0, 32'h0000_1010);
        apply(32'hAC020000, 32'h0000_C000, 32'h12345678, 32'h0000_1014);
        apply(32'h8C030000, 32'h0000_C000, 32'd0, 32'h0000_1018);
        apply(32'hAC020000, 32'h0000_3000, 32'hCAFEF00D, 32'h0000_101C);
        apply(32'h8C030000, 32'h0000_3000, 32'd0, 32'h0000_1020);
        apply(32'hAC020000, 32'h0000_2FFC, 32'h0BADCAFE, 32'h0000_1024);
        apply(32'h8C030000, 32'h0000_2FFE, 32'd0, 32'h0000_1028);
        apply(32'h10220003, 32'd5, 32'd5, 32'h0000_102C);
        apply(32'h10220003, 32'd5, 32'd6, 32'h0000_1030);
        apply(32'h0C000C00, 32'd0, 32'd0, 32'h0000_3004);
        apply(32'h03E00008, 32'h0000_3004, 32'd0, 32'h0000_3008);
        apply(32'h00221821, 32'hFFFFFFFF, 32'h1, 32'h0000_300C);
        apply(32'h3C03ABCD, 32'd0, 32'd0, 32'h0000_3010);
        apply(32'h00000000, 32'h1111, 32'h1111, 32'h0000_3014);

        // sw with reset dropped part-way through its cycle; the store must not land
        #1;
        drive(32'hAC020008, 32'd0, 32'h55AA55AA, 32'h0000_3018);
        e = model(32'hAC020008, 32'd0, 32'h55AA55AA, 32'h0000_3018, 1'b0);
        sb_q.push_back(e);
        #2 rst = 1'b0;
        mem_model.delete();
        @(posedge clk);
        apply(32'h8C030008, 32'd0, 32'd0, 32'h0000_301C);
        #1 rst = 1'b1;
        @(posedge clk);
        apply(32'h8C030008, 32'd0, 32'd0, 32'h0000_3020);
        apply(32'h8C030004, 32'd0, 32'd0, 32'h0000_3024);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            ins = rand_instr(rs, rt);
            apply(ins, rs, rt, $urandom);
        end

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
